dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the word-addressed, synchronous data memory (read data registered one clock after the read strobe). It shares the single memory port between the CPU (port 0) and a loader/DMA engine (port 1), using round-robin grants. It issues exactly one memory command at a time and returns a registered acknowledge, read data and an out-of-range error to the owning requester.

## Interface
- DATA_W, 32, data width of requests and memory
- ADDR_W, 32, word-address width
- DEPTH, 8192, number of memory words; valid addresses are 0..DEPTH-1
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request from port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  pulses with ack when the address was out of range
- rdata0 / rdata1  out  DATA_W  read data, valid only in the ack cycle of a read
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_address  out  ADDR_W  memory word address
- mem_write_data  out  DATA_W  memory write data
- mem_read_data  in  DATA_W  registered memory read data

## Operation
- FSM states: IDLE, ISSUE, RWAIT. All outputs are registered.
- **IDLE**
  - Samples req0/req1.
  - Only one requesting: that port wins.
  - Both requesting: the port not granted last wins. The last-grant pointer resets to 1, so port 0 wins the first tie.
  - At the grant edge, latch we, addr and wdata of the winner and update the pointer.
- **Range check at grant**
  - addr >= DEPTH: no memory access. ackN=1 and errN=1 next cycle, rdataN=0, stay in IDLE.
  - Otherwise go to ISSUE.
- **ISSUE (one cycle)**
  - mem_address and mem_write_data come from the latched command.
  - mem_write=we, mem_read=!we.
  - Write: go to IDLE with ackN=1 in the next cycle.
  - Read: go to RWAIT.
- **RWAIT (one cycle)**
  - Strobes low.
  - Capture mem_read_data into rdataN and assert ackN=1 next cycle.
  - Go to IDLE.
- **Idle outputs:** mem_write, mem_read, mem_address and mem_write_data are 0 outside ISSUE. rdataN holds its value after ack but is defined only in the ack cycle. err is never set on in-range accesses.
- **Consumption rule:** in the cycle ackN is high, the arbiter ignores reqN. That port takes a one-cycle bubble, so a synchronous requester can deassert req or update its fields. The other port may be granted in that cycle.
- **Request holding:** requesters hold req and fields stable until ack. A request that drops before grant is simply not served.
- **Reset**
  - All outputs go to 0, state to IDLE, pointer to 1. Any in-flight command is dropped without ack.
  - If reset is sampled at the edge ending ISSUE, the memory also samples the strobe at that edge, so a write does complete. No ack is given.

## Timing
- Grant at edge ending cycle N.
- Write: mem_write high in N+1; ack in N+2.
- Read: mem_read high in N+1; mem_read_data valid in N+2; ack+rdata in N+3.
- Out-of-range: ack+err in N+1; no strobe ever.
- Maximum throughput: one write per 2 cycles, one read per 3 cycles. A single port is served every 3 or 4 cycles because of the ack bubble.
- Exactly one of ack0/ack1 can be high in any cycle. mem_write and mem_read are never high together.

## Test plan
- **Reset values:** hold reset 2 cycles with req0=req1=1 -> all outputs 0. First grant after release goes to port 0.
- **Write then read:** port 0 writes 0xDEADBEEF to addr 5 (mem_write high N+1, ack0 at N+2). Port 0 then reads addr 5 -> mem_read high one cycle, ack0 with rdata0=0xDEADBEEF exactly 3 cycles after its grant edge.
- **Round-robin:** req0 and req1 held high with reads -> grants alternate 0,1,0,1. Each ack carries its own port's data, and ack0/ack1 are never high together.
- **Range error:** port 1 writes addr 8192 -> ack1=err1=1 in N+1, no mem_write, memory contents unchanged. Addr 8191 succeeds with err1=0.
- **Reset mid-read:** assert reset during RWAIT -> no ack, rdata 0, state IDLE. A next request is granted normally.
- **Reset mid-write:** assert reset on the edge ending ISSUE of a write to addr 7 -> memory word 7 updated, no ack1 pulse.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter.
// One instance per requester port.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  err,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output err,
        output rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one synchronous data-memory port
// between the CPU (port0) and a loader/DMA engine (port1).
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8192
) (
    input  logic              clock,
    input  logic              reset,
    dmem_arbiter_if.slave     port0,
    dmem_arbiter_if.slave     port1,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RWAIT = 2'd2;

    logic [1:0]        state;
    logic              last;
    logic              own;
    logic              cmd_we;
    logic              ack0_q;
    logic              ack1_q;
    logic              err0_q;
    logic              err1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              r0;
    logic              r1;
    logic              gnt;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    assign port0.ack   = ack0_q;
    assign port0.err   = err0_q;
    assign port0.rdata = rdata0_q;
    assign port1.ack   = ack1_q;
    assign port1.err   = err1_q;
    assign port1.rdata = rdata1_q;

    // A port being acked this cycle is masked so it takes its bubble.
    always_comb begin
        r0        = port0.req & ~ack0_q;
        r1        = port1.req & ~ack1_q;
        gnt       = r0 | r1;
        pick      = r1 & (~r0 | ~last);
        sel_we    = pick ? port1.we : port0.we;
        sel_addr  = pick ? port1.addr : port0.addr;
        sel_wdata = pick ? port1.wdata : port0.wdata;
        in_range  = {1'b0, sel_addr} < (ADDR_W+1)'(DEPTH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            last           <= 1'b1;
            own            <= 1'b0;
            cmd_we         <= 1'b0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            err0_q         <= 1'b0;
            err1_q         <= 1'b0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            err0_q         <= 1'b0;
            err1_q         <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt) begin
                        last   <= pick;
                        own    <= pick;
                        cmd_we <= sel_we;
                        if (in_range) begin
                            state          <= ISSUE;
                            mem_write      <= sel_we;
                            mem_read       <= ~sel_we;
                            mem_address    <= sel_addr;
                            mem_write_data <= sel_wdata;
                        end else if (pick) begin
                            ack1_q   <= 1'b1;
                            err1_q   <= 1'b1;
                            rdata1_q <= '0;
                        end else begin
                            ack0_q   <= 1'b1;
                            err0_q   <= 1'b1;
                            rdata0_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_we) begin
                        state <= IDLE;
                        if (own) ack1_q <= 1'b1;
                        else     ack0_q <= 1'b1;
                    end else begin
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    state <= IDLE;
                    if (own) begin
                        ack1_q   <= 1'b1;
                        rdata1_q <= mem_read_data;
                    end else begin
                        ack0_q   <= 1'b1;
                        rdata0_q <= mem_read_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + randomized bench for dmem_arbiter against a transaction-level
// model of memory contents, latencies and round-robin order.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int vectors     = 0;
    int miscompares = 0;
    int last_grant  = 1;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem [0:8191];

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) p0 ();
    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) p1 ();

    dmem_arbiter #(
        .DATA_W(32),
        .ADDR_W(32),
        .DEPTH (8192)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .port0         (p0),
        .port1         (p1),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    always #5 clock = ~clock;

    // Synchronous memory; aliasing on the low 13 bits exposes stray writes.
    always @(posedge clock) begin
        if (mem_write) mem[mem_address[12:0]] <= mem_write_data;
        if (mem_read)  mem_read_data <= mem[mem_address[12:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int port, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0.req = r; p0.we = w; p0.addr = a; p0.wdata = d;
        end else begin
            p1.req = r; p1.we = w; p1.addr = a; p1.wdata = d;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ack0"}, p0.ack, 0);
        chk({tag, "_ack1"}, p1.ack, 0);
        chk({tag, "_err0"}, p0.err, 0);
        chk({tag, "_err1"}, p1.err, 0);
        chk({tag, "_rdata0"}, p0.rdata, 0);
        chk({tag, "_rdata1"}, p1.rdata, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_wdata"}, mem_write_data, 0);
    endtask

    // One isolated transaction; latency counted in edges after the grant edge.
    task automatic txn(input int port, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
        logic        inr;
        logic        got;
        int          lat;
        logic [31:0] exp_rd;
        inr    = addr < 32'd8192;
        lat    = !inr ? 1 : (we ? 2 : 3);
        exp_rd = (inr && ref_mem.exists(addr)) ? ref_mem[addr] : 32'h0;
        got    = 1'b0;
        @(negedge clock);
        drive(port, 1'b1, we, addr, wd);
        @(posedge clock);
        for (int n = 1; n <= 6 && !got; n++) begin
            @(negedge clock);
            chk("mem_write", mem_write, (n == 1) && we && inr);
            chk("mem_read", mem_read, (n == 1) && !we && inr);
            if (n == 1 && inr) chk("mem_address", mem_address, addr);
            if (n == 1 && inr && we) chk("mem_write_data", mem_write_data, wd);
            chk("ack_other", port != 0 ? p0.ack : p1.ack, 0);
            if (port != 0 ? p1.ack : p0.ack) begin
                got = 1'b1;
                chk("ack_latency", n, lat);
                chk("err", port != 0 ? p1.err : p0.err, !inr);
                if (!we || !inr)
                    chk("rdata", port != 0 ? p1.rdata : p0.rdata, exp_rd);
                drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk("ack_timeout", got, 1);
        drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
        if (inr && we) ref_mem[addr] = wd;
        last_grant = port;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          expp;
        int          nack;
        int          port;
        logic        seen;
        logic [31:0] a;
        logic [31:0] d;

        // Reset held two cycles with both ports requesting.
        drive(0, 1'b1, 1'b0, 32'd3, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd4, 32'h0);
        @(negedge clock);
        check_idle("reset1");
        @(negedge clock);
        check_idle("reset2");
        reset = 1'b0;
        seen  = 1'b0;
        @(posedge clock);
        for (int n = 1; n <= 6 && !seen; n++) begin
            @(negedge clock);
            chk("first_ack1", p1.ack, 0);
            if (p0.ack) begin
                seen = 1'b1;
                chk("first_latency", n, 3);
                drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk("first_grant_port0", seen, 1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        last_grant = 0;

        // Preload addresses 0..15 and the top word.
        for (int i = 0; i < 16; i++) begin
            if (i == 5) txn(0, 1'b1, 32'd5, 32'hDEADBEEF);
            else        txn(i % 2, 1'b1, i, $urandom);
        end
        txn(1, 1'b1, 32'd8191, $urandom);
        txn(0, 1'b0, 32'd5, 32'h0);

        // Round-robin with both ports holding reads.
        expp = 1 - last_grant;
        nack = 0;
        drive(0, 1'b1, 1'b0, 32'd10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd11, 32'h0);
        for (int n = 0; n < 40 && nack < 4; n++) begin
            @(negedge clock);
            chk("ack_exclusive", p0.ack & p1.ack, 0);
            chk("strobe_exclusive", mem_write & mem_read, 0);
            if (p0.ack || p1.ack) begin
                port = p1.ack ? 1 : 0;
                chk("rr_order", port, expp);
                chk("rr_rdata", port != 0 ? p1.rdata : p0.rdata,
                    ref_mem[port != 0 ? 32'd11 : 32'd10]);
                last_grant = port;
                expp = 1 - port;
                nack++;
                if (nack == 4) begin
                    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
                    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
        end
        chk("rr_ack_count", nack, 4);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Out of range must not touch memory (8192 aliases word 0 here).
        txn(1, 1'b1, 32'd8192, 32'h12345678);
        txn(0, 1'b0, 32'd0, 32'h0);
        txn(1, 1'b1, 32'd8191, 32'hCAFEF00D);
        txn(1, 1'b0, 32'd8191, 32'h0);
        txn(0, 1'b0, 32'hFFFFFFFF, 32'h0);

        // Reset during RWAIT drops the read.
        @(negedge clock);
        drive(0, 1'b1, 1'b0, 32'd12, 32'h0);
        @(posedge clock);
        @(negedge clock);
        chk("rst_rd_issue", mem_read, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_idle("rst_rd");
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        last_grant = 1;
        txn(0, 1'b0, 32'd12, 32'h0);

        // Reset at the edge ending ISSUE still lands the write.
        d = $urandom;
        @(negedge clock);
        drive(1, 1'b1, 1'b1, 32'd7, d);
        @(posedge clock);
        @(negedge clock);
        chk("rst_wr_issue", mem_write, 1);
        reset = 1'b1;
        @(negedge clock);
        check_idle("rst_wr");
        reset = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        ref_mem[32'd7] = d;
        last_grant = 1;
        txn(0, 1'b0, 32'd7, 32'h0);

        // Randomized single transactions.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'd8192 + $urandom_range(0, 5000);
                1:       a = 32'd8191;
                default: a = $urandom_range(0, 15);
            endcase
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
